// File: rtl/risc_host_ctrl_if.sv
// Host/core/memory bundle for the run controller.
// slave: controller side; master: host/core side.
interface risc_host_ctrl_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int OUT_DEPTH = 8,
  parameter int CYC_W     = 32
) ();
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  logic              ext_inst_we;
  logic              ext_data_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_data;
  logic              host_cmd_valid;
  logic [1:0]        host_cmd;
  logic              host_cmd_ready;
  logic              imem_we;
  logic              dmem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_en;
  logic              core_rst_n;
  logic              core_out_valid;
  logic [DATA_W-1:0] core_out_data;
  logic              core_halt;
  logic              out_rd;
  logic [DATA_W-1:0] out_data;
  logic              out_empty;
  logic              out_full;
  logic [CW-1:0]     out_count;
  logic              out_overflow;
  logic [2:0]        state;
  logic              done;
  logic [CYC_W-1:0]  cycle_count;

  modport slave (
    input  ext_inst_we, ext_data_we,
    input  ext_addr, ext_data,
    input  host_cmd_valid, host_cmd,
    output host_cmd_ready,
    output imem_we, dmem_we,
    output mem_addr, mem_wdata,
    output core_en, core_rst_n,
    input  core_out_valid, core_out_data,
    input  core_halt, out_rd,
    output out_data, out_empty, out_full,
    output out_count, out_overflow,
    output state, done, cycle_count
  );

  modport master (
    output ext_inst_we, ext_data_we,
    output ext_addr, ext_data,
    output host_cmd_valid, host_cmd,
    input  host_cmd_ready,
    input  imem_we, dmem_we,
    input  mem_addr, mem_wdata,
    input  core_en, core_rst_n,
    output core_out_valid, core_out_data,
    output core_halt, out_rd,
    input  out_data, out_empty, out_full,
    input  out_count, out_overflow,
    input  state, done, cycle_count
  );
endinterface

// File: rtl/risc_host_ctrl.sv
// Host run controller: memory load port, run/step/stop/clear,
// OutR FWFT capture FIFO, cycle counter, halt report.
// Ports: clk, rst (async active-low), bus (slave modport).
module risc_host_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int OUT_DEPTH = 8,
  parameter int CYC_W     = 32
) (
  input  logic clk,
  input  logic rst,
  risc_host_ctrl_if.slave bus
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(OUT_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam logic [1:0] C_RUN  = 2'b00;
  localparam logic [1:0] C_STEP = 2'b01;
  localparam logic [1:0] C_STOP = 2'b10;
  localparam logic [1:0] C_CLR  = 2'b11;

  state_e r_state, w_nstate;
  logic r_step, w_nstep;
  logic r_en, w_nen;
  logic r_rstn, w_nrstn;
  logic w_cnt_clr, w_fifo_clr;

  logic w_acc, w_run, w_stp, w_stop, w_clr;
  logic w_we, w_wr, w_halt;

  assign w_acc  = bus.host_cmd_valid
                & (r_state != S_LOAD);
  assign w_run  = w_acc & (bus.host_cmd == C_RUN);
  assign w_stp  = w_acc & (bus.host_cmd == C_STEP);
  assign w_stop = w_acc & (bus.host_cmd == C_STOP);
  assign w_clr  = w_acc & (bus.host_cmd == C_CLR);
  assign w_we   = bus.ext_inst_we | bus.ext_data_we;
  assign w_halt = r_en & bus.core_halt;
  assign w_wr   = w_we & ((r_state == S_IDLE)
                | (r_state == S_LOAD)
                | (r_state == S_HALT));

  always_comb begin
    w_nstate   = r_state;
    w_nstep    = 1'b0;
    w_cnt_clr  = 1'b0;
    w_fifo_clr = 1'b0;
    if (w_clr) begin
      w_nstate   = S_IDLE;
      w_cnt_clr  = 1'b1;
      w_fifo_clr = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_we) w_nstate = S_LOAD;
          else if (w_run) begin
            w_nstate  = S_RUN;
            w_cnt_clr = 1'b1;
          end else if (w_stp) begin
            w_nstate = S_RUN;
            w_nstep  = 1'b1;
          end
        end
        S_LOAD: if (!w_we) w_nstate = S_IDLE;
        S_RUN: begin
          // halt outranks stop and step completion
          if (w_halt) w_nstate = S_HALT;
          else if (w_stop) w_nstate = S_PAUSE;
          else if (r_step && w_stp) w_nstep = 1'b1;
          else if (r_step && !w_run)
            w_nstate = S_PAUSE;
        end
        S_PAUSE: begin
          if (w_run) w_nstate = S_RUN;
          else if (w_stp) begin
            w_nstate = S_RUN;
            w_nstep  = 1'b1;
          end
        end
        S_HALT: begin
          if (w_we) w_nstate = S_LOAD;
          else if (w_run) begin
            w_nstate  = S_RUN;
            w_cnt_clr = 1'b1;
          end
        end
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  // restart from HALT spends its entry cycle in core reset
  logic w_restart;
  assign w_restart = (r_state == S_HALT)
                   & (w_nstate == S_RUN);
  assign w_nen   = (w_nstate == S_RUN) & ~w_restart;
  assign w_nrstn = ((w_nstate == S_RUN)
                 | (w_nstate == S_PAUSE)
                 | (w_nstate == S_HALT)) & ~w_restart;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_step  <= 1'b0;
      r_en    <= 1'b0;
      r_rstn  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_step  <= w_nstep;
      r_en    <= w_nen;
      r_rstn  <= w_nrstn;
    end
  end

  logic              r_imem_we, r_dmem_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_imem_we <= w_wr & bus.ext_inst_we;
      r_dmem_we <= w_wr & bus.ext_data_we
                 & ~bus.ext_inst_we;
      if (w_wr) begin
        r_addr  <= bus.ext_addr;
        r_wdata <= bus.ext_data;
      end
    end
  end

  logic [CYC_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else if (w_cnt_clr) r_cnt <= '0;
    else if (r_en && (r_cnt != {CYC_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  logic [DATA_W-1:0] r_mem [OUT_DEPTH];
  logic [AW:0]       r_wp, r_rp, w_cnt;
  logic              r_ovf;
  logic w_push, w_pop, w_push_ok, w_full, w_empty;

  assign w_cnt     = r_wp - r_rp;
  assign w_full    = (w_cnt == FULL_C);
  assign w_empty   = (r_wp == r_rp);
  assign w_push    = bus.core_out_valid & r_en;
  assign w_pop     = bus.out_rd & ~w_empty;
  assign w_push_ok = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_fifo_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wp[AW-1:0]] <= bus.core_out_data;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
    end
  end

  assign bus.host_cmd_ready = (r_state != S_LOAD);
  assign bus.imem_we      = r_imem_we;
  assign bus.dmem_we      = r_dmem_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.core_en      = r_en;
  assign bus.core_rst_n   = r_rstn;
  assign bus.out_data     = r_mem[r_rp[AW-1:0]];
  assign bus.out_empty    = w_empty;
  assign bus.out_full     = w_full;
  assign bus.out_count    = w_cnt;
  assign bus.out_overflow = r_ovf;
  assign bus.state        = r_state;
  assign bus.done         = (r_state == S_HALT);
  assign bus.cycle_count  = r_cnt;
endmodule

// File: tb/tb_risc_host_ctrl.sv
// Self-checking bench for risc_host_ctrl.
// Scoreboard queues hold expected mem writes and FIFO words.
module tb_risc_host_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [24:0] q_mem [$];
  logic [15:0] q_out [$];

  risc_host_ctrl_if bus ();

  risc_host_ctrl dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    bus.host_cmd_valid = 1'b1;
    bus.host_cmd = c;
    tick();
    bus.host_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.state !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_state got %0d exp 0", bus.state);
    end
    n_cmp++;
    if ({bus.core_en, bus.core_rst_n} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_core got %b exp 00",
               {bus.core_en, bus.core_rst_n});
    end
    n_cmp++;
    if ({bus.out_empty, bus.out_overflow} !== 2'b10) begin
      n_bad++;
      $display("FAIL rst_fifo got %b exp 10",
               {bus.out_empty, bus.out_overflow});
    end
    n_cmp++;
    if (bus.cycle_count !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_cnt got %0d exp 0", bus.cycle_count);
    end
    n_cmp++;
    if (bus.host_cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready got %b exp 1", bus.host_cmd_ready);
    end
  endtask

  task automatic test_load();
    logic [24:0] e;
    for (int i = 0; i < 5; i++) begin
      bus.ext_inst_we = (i < 4);
      bus.ext_data_we = (i == 4);
      bus.ext_addr = (i < 4) ? 8'(i) : 8'h05;
      bus.ext_data = (i < 4) ? 16'(16'h1111 * (i + 1))
                             : 16'hABCD;
      q_mem.push_back({bus.ext_inst_we, bus.ext_addr,
                       bus.ext_data});
      tick();
      e = q_mem.pop_front();
      n_cmp++;
      if ({bus.imem_we, bus.dmem_we} !== {e[24], ~e[24]}) begin
        n_bad++;
        $display("FAIL load_we[%0d] got %b exp %b", i,
                 {bus.imem_we, bus.dmem_we}, {e[24], ~e[24]});
      end
      n_cmp++;
      if ({bus.mem_addr, bus.mem_wdata} !== e[23:0]) begin
        n_bad++;
        $display("FAIL load_ad[%0d] got %h exp %h", i,
                 {bus.mem_addr, bus.mem_wdata}, e[23:0]);
      end
      if (i == 0) begin
        n_cmp++;
        if ({bus.state, bus.host_cmd_ready} !== 4'b0010) begin
          n_bad++;
          $display("FAIL load_state got %b exp 0010",
                   {bus.state, bus.host_cmd_ready});
        end
      end
    end
    bus.ext_inst_we = 1'b0;
    bus.ext_data_we = 1'b0;
    tick();
    n_cmp++;
    if ({bus.imem_we, bus.dmem_we} !== 2'b00) begin
      n_bad++;
      $display("FAIL load_end_we got %b exp 00",
               {bus.imem_we, bus.dmem_we});
    end
    n_cmp++;
    if ({bus.state, bus.core_rst_n} !== 4'b0000) begin
      n_bad++;
      $display("FAIL load_idle got %b exp 0000",
               {bus.state, bus.core_rst_n});
    end
  endtask

  task automatic test_run_halt();
    send_cmd(2'b00);
    n_cmp++;
    if ({bus.state, bus.core_en, bus.core_rst_n}
        !== 5'b01011) begin
      n_bad++;
      $display("FAIL run_start got %b exp 01011",
               {bus.state, bus.core_en, bus.core_rst_n});
    end
    repeat (9) tick();
    bus.core_halt = 1'b1;
    tick();
    bus.core_halt = 1'b0;
    n_cmp++;
    if (bus.cycle_count !== 32'd10) begin
      n_bad++;
      $display("FAIL halt_cnt got %0d exp 10", bus.cycle_count);
    end
    n_cmp++;
    if ({bus.state, bus.done, bus.core_en} !== 5'b10010) begin
      n_bad++;
      $display("FAIL halt_st got %b exp 10010",
               {bus.state, bus.done, bus.core_en});
    end
    send_cmd(2'b00);
    n_cmp++;
    if ({bus.state, bus.core_en, bus.core_rst_n}
        !== 5'b01000 || bus.cycle_count !== 32'd0) begin
      n_bad++;
      $display("FAIL restart_pulse got %b/%0d exp 01000/0",
               {bus.state, bus.core_en, bus.core_rst_n},
               bus.cycle_count);
    end
    tick();
    n_cmp++;
    if ({bus.core_en, bus.core_rst_n} !== 2'b11
        || bus.cycle_count !== 32'd0) begin
      n_bad++;
      $display("FAIL restart_run got %b/%0d exp 11/0",
               {bus.core_en, bus.core_rst_n}, bus.cycle_count);
    end
    tick();
    send_cmd(2'b10);
    n_cmp++;
    if (bus.cycle_count !== 32'd2 || bus.state !== 3'd3) begin
      n_bad++;
      $display("FAIL restart_cnt got %0d/%0d exp 2/3",
               bus.cycle_count, bus.state);
    end
    send_cmd(2'b11);
  endtask

  task automatic test_step_pause();
    logic rst_ok;
    send_cmd(2'b01);
    n_cmp++;
    if ({bus.state, bus.core_en, bus.core_rst_n}
        !== 5'b01011) begin
      n_bad++;
      $display("FAIL step_on got %b exp 01011",
               {bus.state, bus.core_en, bus.core_rst_n});
    end
    tick();
    n_cmp++;
    if ({bus.state, bus.core_en} !== 4'b0110
        || bus.cycle_count !== 32'd1) begin
      n_bad++;
      $display("FAIL step_off got %b/%0d exp 0110/1",
               {bus.state, bus.core_en}, bus.cycle_count);
    end
    rst_ok = bus.core_rst_n;
    send_cmd(2'b00);
    rst_ok &= bus.core_rst_n;
    tick();
    rst_ok &= bus.core_rst_n;
    tick();
    rst_ok &= bus.core_rst_n;
    send_cmd(2'b10);
    rst_ok &= bus.core_rst_n;
    n_cmp++;
    if (bus.cycle_count !== 32'd4 || bus.state !== 3'd3) begin
      n_bad++;
      $display("FAIL pause_cnt got %0d/%0d exp 4/3",
               bus.cycle_count, bus.state);
    end
    n_cmp++;
    if (rst_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL pause_rstn got %b exp 1", rst_ok);
    end
  endtask

  task automatic test_fifo_overflow();
    send_cmd(2'b00);
    for (int i = 1; i <= 9; i++) begin
      bus.core_out_valid = 1'b1;
      bus.core_out_data = 16'(i);
      if (i <= 8) q_out.push_back(16'(i));
      tick();
    end
    bus.core_out_valid = 1'b0;
    send_cmd(2'b10);
    n_cmp++;
    if ({bus.out_full, bus.out_overflow} !== 2'b11
        || bus.out_count !== 4'd8) begin
      n_bad++;
      $display("FAIL ovf_flags got %b/%0d exp 11/8",
               {bus.out_full, bus.out_overflow}, bus.out_count);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus.out_data !== q_out[0]) begin
        n_bad++;
        $display("FAIL ovf_rd[%0d] got %h exp %h", i,
                 bus.out_data, q_out[0]);
      end
      void'(q_out.pop_front());
      bus.out_rd = 1'b1;
      tick();
      bus.out_rd = 1'b0;
    end
    n_cmp++;
    if (bus.out_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_empty got %b exp 1", bus.out_empty);
    end
  endtask

  task automatic test_full_push_pop();
    send_cmd(2'b00);
    for (int i = 0; i < 8; i++) begin
      bus.core_out_valid = 1'b1;
      bus.core_out_data = 16'(16'h10 + i);
      q_out.push_back(16'(16'h10 + i));
      tick();
    end
    bus.core_out_data = 16'h00FF;
    bus.out_rd = 1'b1;
    n_cmp++;
    if (bus.out_data !== q_out[0]) begin
      n_bad++;
      $display("FAIL pp_head got %h exp %h",
               bus.out_data, q_out[0]);
    end
    void'(q_out.pop_front());
    q_out.push_back(16'h00FF);
    tick();
    bus.out_rd = 1'b0;
    bus.core_out_valid = 1'b0;
    send_cmd(2'b10);
    n_cmp++;
    if (bus.out_count !== 4'd8 || bus.out_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL pp_flags got %0d/%b exp 8/1",
               bus.out_count, bus.out_overflow);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus.out_data !== q_out[0]) begin
        n_bad++;
        $display("FAIL pp_rd[%0d] got %h exp %h", i,
                 bus.out_data, q_out[0]);
      end
      void'(q_out.pop_front());
      bus.out_rd = 1'b1;
      tick();
      bus.out_rd = 1'b0;
    end
  endtask

  task automatic test_illegal_clear();
    send_cmd(2'b00);
    bus.ext_inst_we = 1'b1;
    bus.ext_addr = 8'h33;
    bus.ext_data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      bus.core_out_valid = 1'b1;
      bus.core_out_data = 16'(16'h20 + i);
      tick();
      n_cmp++;
      if ({bus.imem_we, bus.state} !== 4'b0010) begin
        n_bad++;
        $display("FAIL ill_we[%0d] got %b exp 0010", i,
                 {bus.imem_we, bus.state});
      end
    end
    bus.ext_inst_we = 1'b0;
    bus.core_out_valid = 1'b0;
    send_cmd(2'b10);
    n_cmp++;
    if (bus.out_count !== 4'd3) begin
      n_bad++;
      $display("FAIL ill_cnt got %0d exp 3", bus.out_count);
    end
    send_cmd(2'b11);
    n_cmp++;
    if ({bus.state, bus.out_empty, bus.out_overflow}
        !== 5'b00010 || bus.cycle_count !== 32'd0) begin
      n_bad++;
      $display("FAIL clear got %b/%0d exp 00010/0",
               {bus.state, bus.out_empty, bus.out_overflow},
               bus.cycle_count);
    end
  endtask

  task automatic test_async_reset();
    send_cmd(2'b00);
    bus.core_out_valid = 1'b1;
    bus.core_out_data = 16'h7777;
    tick();
    bus.core_out_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.state, bus.core_en, bus.core_rst_n,
         bus.out_empty} !== 6'b000001
        || bus.cycle_count !== 32'd0) begin
      n_bad++;
      $display("FAIL arst got %b/%0d exp 000001/0",
               {bus.state, bus.core_en, bus.core_rst_n,
                bus.out_empty}, bus.cycle_count);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.ext_inst_we = 1'b0;
    bus.ext_data_we = 1'b0;
    bus.ext_addr = '0;
    bus.ext_data = '0;
    bus.host_cmd_valid = 1'b0;
    bus.host_cmd = 2'b00;
    bus.core_out_valid = 1'b0;
    bus.core_out_data = '0;
    bus.core_halt = 1'b0;
    bus.out_rd = 1'b0;
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_load();
    test_run_halt();
    test_step_pause();
    test_fifo_overflow();
    test_full_push_pop();
    test_illegal_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/risc_host_ctrl.md
# risc_host_ctrl

Host-side run controller for the 16-bit pipelined RISC core. It loads the instruction and data memories through an external write port and gives the core a clock enable and a core reset. It adds explicit run, single-step, stop and clear commands, in place of the toggle-on-write-release scheme. It also captures OutR results in a parametrised first-word-fall-through FIFO, counts executed cycles, and reports halt.

## Interface
- DATA_W, 16, datapath and memory word width
- ADDR_W, 8, memory address width
- OUT_DEPTH, 8, OutR capture FIFO depth (power of two, ≥2)
- CYC_W, 32, cycle counter width
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ext_inst_we  in  1  host write strobe, instruction memory
- ext_data_we  in  1  host write strobe, data memory
- ext_addr  in  ADDR_W  host write address
- ext_data  in  DATA_W  host write data
- host_cmd_valid  in  1  command strobe
- host_cmd  in  2  00 RUN, 01 STEP, 10 STOP, 11 CLEAR
- host_cmd_ready  out  1  command accepted this cycle when valid&ready
- imem_we / dmem_we  out  1  registered memory write enables
- mem_addr  out  ADDR_W  registered write address
- mem_wdata  out  DATA_W  registered write data
- core_en  out  1  core clock enable
- core_rst_n  out  1  core synchronous reset, active-low
- core_out_valid  in  1  core OutR instruction retiring
- core_out_data  in  DATA_W  OutR value
- core_halt  in  1  core HLT retiring
- out_rd  in  1  pop FIFO head
- out_data  out  DATA_W  FIFO head (FWFT)
- out_empty / out_full  out  1  FIFO flags
- out_count  out  $clog2(OUT_DEPTH)+1  FIFO occupancy
- out_overflow  out  1  sticky, a push was dropped
- state  out  3  IDLE=0, LOAD=1, RUN=2, PAUSE=3, HALT=4
- done  out  1  high in HALT
- cycle_count  out  CYC_W  enabled core cycles since last RUN-from-IDLE/HALT, saturating

## Operation
- **Reset values.** All registers reset to 0. state=IDLE, core_en=0, core_rst_n=0, FIFO empty, out_overflow=0, cycle_count=0.
- **host_cmd_ready.** Combinational, equal to (state≠LOAD).
- **IDLE.** Core held in reset (core_rst_n=0, core_en=0).
  - Any ext_*_we → LOAD.
  - RUN → RUN.
  - STEP → one enabled cycle, then PAUSE.
  - STOP ignored.
- **LOAD.** Each cycle with a strobe high, register addr/data/enables to the mem_* outputs.
  - Both strobes high: instruction write only, dmem_we=0.
  - First cycle with both strobes low → IDLE. The core never starts automatically.
- **RUN.** core_rst_n=1, core_en=1.
  - Entered from IDLE or HALT: cycle_count cleared to 0 at entry.
  - Entered from HALT: core_rst_n is additionally held low for exactly one cycle (the entry cycle, core_en=0 during it), restarting the program.
  - STOP → PAUSE. core_halt → HALT.
- **PAUSE.** core_rst_n=1, core_en=0; pipeline state preserved.
  - RUN → RUN with no reset pulse and no counter clear.
  - STEP → one enabled cycle, then PAUSE again (HALT if core_halt seen in that cycle).
- **HALT.** done=1, core_en=0, core_rst_n=1.
  - Strobes → LOAD. RUN → restart as above. STEP ignored.
- **CLEAR.** Accepted in any state except LOAD → IDLE. Flushes the FIFO, clears out_overflow and cycle_count.
- **Writes outside IDLE/HALT.** ext writes in RUN/PAUSE are dropped: no mem_* write, no state change.
- **core_halt and core_out_valid** are sampled only in cycles with core_en=1; ignored otherwise.
- **FIFO.**
  - Push on core_out_valid&core_en.
  - Pop on out_rd&~out_empty; pop when empty is ignored.
  - Push while full: dropped, out_overflow set, unless a pop occurs the same cycle, in which case both succeed.
  - Push while empty: data visible on out_data the next cycle.
  - Pointers wrap modulo OUT_DEPTH.
- **cycle_count** increments on every core_en=1 cycle and saturates at 2^CYC_W−1.
- **Same-cycle core_halt and STOP:** HALT wins.

## Timing
- Commands take effect at the accepting posedge. core_en/core_rst_n are registered and reflect the new state in the following cycle.
- Memory write latency: 1 cycle from strobe to imem_we/dmem_we.
- STEP yields exactly one core_en=1 cycle, starting the cycle after acceptance.
- HALT: core_en=0 in the cycle after core_halt is sampled; done=1 in the same cycle.
- Async reset mid-LOAD or mid-RUN: all outputs return to reset values immediately; FIFO contents are discarded.

## Test plan
- **Load then idle.** Reset; write imem addr 0..3 = 0x1111..0x4444, then dmem addr 5 = 0xABCD with strobes.
  - Expect each imem_we pulse one cycle late with matching mem_addr/mem_wdata, then dmem_we with addr 5 / 0xABCD.
  - Expect state back to IDLE, core_rst_n=0.
- **Run to halt.** RUN from IDLE; core_halt pulsed on the 10th enabled cycle.
  - Expect cycle_count=10, done=1, core_en=0 the next cycle.
  - Then RUN again: one-cycle core_rst_n low, cycle_count restarts at 0.
- **Step/pause.** STEP from IDLE → exactly one core_en cycle → PAUSE.
  - Then RUN, then STOP after 3 cycles: cycle_count=4, core_rst_n stays 1 throughout.
- **FIFO overflow.** OUT_DEPTH=8; push 9 values 0x0001..0x0009 with no reads.
  - Expect out_full=1, out_overflow=1, out_count=8.
  - Reading 8 times returns 0x0001..0x0008.
- **Full push+pop.** With the FIFO full, assert out_rd and core_out_valid (0x00FF) in the same cycle.
  - Expect out_count stays 8, out_overflow unchanged, 0x00FF appears as the last entry.
- **Illegal load / CLEAR.** ext_inst_we during RUN: expect no imem_we.
  - CLEAR in PAUSE with 3 FIFO entries: expect IDLE, out_empty=1, cycle_count=0, out_overflow=0.
